// File: rtl/multicycle_datapath.sv
// Multicycle datapath: register file, ALU, PC logic and control FSM.
// Fetches and accesses data over ready/req handshakes, so memories may insert wait states.
module multicycle_datapath #(
    parameter int DWIDTH = 8,
    parameter int IWIDTH = 16,
    parameter int NREGS  = 4
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [IWIDTH-1:0] imem_rdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_ready,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic [DWIDTH-1:0] pc,
    output logic              retire,
    output logic              illegal,
    output logic              halted
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_J    = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t            state;
    state_t            state_nx;
    logic [IWIDTH-1:0] ir;
    logic [DWIDTH-1:0] a;
    logic [DWIDTH-1:0] b;
    logic [DWIDTH-1:0] aluout;
    logic [DWIDTH-1:0] mdr;
    logic [DWIDTH-1:0] rf [NREGS];

    logic [3:0]        op;
    logic [1:0]        rs;
    logic [1:0]        rt;
    logic [1:0]        rd;
    logic [3:0]        funct;
    logic [DWIDTH-1:0] simm;
    logic [DWIDTH-1:0] jtarget;
    logic [DWIDTH-1:0] alu_res;
    logic              funct_ok;

    logic imem_req_c;
    logic dmem_req_c;
    logic retire_c;
    logic illegal_c;

    assign op      = ir[15:12];
    assign rs      = ir[11:10];
    assign rt      = ir[9:8];
    assign rd      = ir[7:6];
    assign funct   = ir[3:0];
    assign simm    = DWIDTH'(signed'(ir[7:0]));
    // Jump target is zero-extended, or truncated when the datapath is narrower than 12 bits.
    assign jtarget = DWIDTH'(ir[11:0]);

    always_comb begin
        alu_res  = '0;
        funct_ok = 1'b1;
        case (funct)
            4'd0:    alu_res = a + b;
            4'd1:    alu_res = a - b;
            4'd2:    alu_res = a & b;
            4'd3:    alu_res = a | b;
            4'd4:    alu_res = {{(DWIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: funct_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            a      <= '0;
            b      <= '0;
            aluout <= '0;
            mdr    <= '0;
            rf     <= '{default: '0};
        end else begin
            state <= state_nx;
            case (state)
                FETCH: begin
                    if (imem_ready) begin
                        ir <= imem_rdata;
                        pc <= pc + DWIDTH'(2);
                    end
                end
                DECODE: begin
                    a <= rf[rs];
                    b <= rf[rt];
                    if (op == OP_J) pc <= jtarget;
                end
                EXEC: begin
                    aluout <= (op == OP_R) ? alu_res : a + simm;
                    // pc already points past the branch, so the offset is applied to pc+2.
                    if (op == OP_BEQ && a == b) pc <= pc + (simm << 1);
                end
                MEM: begin
                    if (dmem_ready && op == OP_LW) mdr <= dmem_rdata;
                end
                WB: begin
                    case (op)
                        OP_R:    rf[rd] <= aluout;
                        OP_ADDI: rf[rt] <= aluout;
                        OP_LW:   rf[rt] <= mdr;
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx   = state;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        retire_c   = 1'b0;
        illegal_c  = 1'b0;
        case (state)
            FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) state_nx = DECODE;
            end
            DECODE: begin
                case (op)
                    OP_J: begin
                        retire_c = 1'b1;
                        state_nx = FETCH;
                    end
                    OP_HALT: begin
                        retire_c = 1'b1;
                        state_nx = HALT;
                    end
                    OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_nx = EXEC;
                    default: begin
                        illegal_c = 1'b1;
                        retire_c  = 1'b1;
                        state_nx  = FETCH;
                    end
                endcase
            end
            EXEC: begin
                case (op)
                    OP_R: begin
                        if (funct_ok) begin
                            state_nx = WB;
                        end else begin
                            retire_c = 1'b1;
                            state_nx = FETCH;
                        end
                    end
                    OP_ADDI:      state_nx = WB;
                    OP_LW, OP_SW: state_nx = MEM;
                    default: begin
                        retire_c = 1'b1;
                        state_nx = FETCH;
                    end
                endcase
            end
            MEM: begin
                dmem_req_c = 1'b1;
                if (dmem_ready) begin
                    if (op == OP_SW) begin
                        retire_c = 1'b1;
                        state_nx = FETCH;
                    end else begin
                        state_nx = WB;
                    end
                end
            end
            WB: begin
                retire_c = 1'b1;
                state_nx = FETCH;
            end
            HALT:    state_nx = HALT;
            default: state_nx = FETCH;
        endcase
    end

    // Control outputs are held low for as long as reset is asserted.
    assign imem_req   = imem_req_c & ~reset;
    assign dmem_req   = dmem_req_c & ~reset;
    assign dmem_we    = dmem_req & (op == OP_SW);
    assign retire     = retire_c & ~reset;
    assign illegal    = illegal_c & ~reset;
    assign halted     = (state == HALT) & ~reset;
    assign imem_addr  = pc;
    assign dmem_addr  = aluout;
    assign dmem_wdata = b;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Bench for multicycle_datapath: directed vector table, hand-written corner sequences,
// and random programs checked against an instruction-level reference model.
module tb_multicycle_datapath;

    localparam int MASK = 'hFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_ready;
    logic [7:0]  dmem_rdata;
    logic [7:0]  pc;
    logic        retire;
    logic        illegal;
    logic        halted;

    multicycle_datapath #(.DWIDTH(8), .IWIDTH(16), .NREGS(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .pc(pc), .retire(retire), .illegal(illegal), .halted(halted)
    );

    always #5 clk = ~clk;

    // Memories with fixed per-run wait counts; ready is random noise while req is low.
    logic [15:0] imem [256];
    logic [7:0]  dmem [256];
    int unsigned iw = 0;
    int unsigned dw = 0;
    int unsigned icnt = 0;
    int unsigned dcnt = 0;
    logic        noise = 1'b0;

    assign imem_ready = imem_req ? (icnt >= iw) : noise;
    assign dmem_ready = dmem_req ? (dcnt >= dw) : noise;
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];

    always @(posedge clk) begin
        noise <= 1'($urandom);
        icnt  <= (imem_req && !imem_ready) ? icnt + 1 : 0;
        dcnt  <= (dmem_req && !dmem_ready) ? dcnt + 1 : 0;
        if (dmem_req && dmem_we && dmem_ready) dmem[dmem_addr] = dmem_wdata;
    end

    // Protocol monitor: request exclusivity and stable data requests across wait cycles.
    int   mon_viol = 0;
    logic rst_edge = 1'b1;
    logic p_dreq = 1'b0, p_drdy = 1'b0, p_dwe = 1'b0;
    logic [7:0] p_daddr = '0, p_dwdata = '0;

    always @(posedge clk) rst_edge <= reset;

    always @(negedge clk) begin
        if (reset || rst_edge) begin
            p_dreq <= 1'b0;
        end else begin
            if (imem_req && dmem_req) begin
                mon_viol = mon_viol + 1;
                $display("FAIL req_exclusive: imem_req=%b dmem_req=%b, required not both high", imem_req, dmem_req);
            end
            if (p_dreq && !p_drdy &&
                (!dmem_req || dmem_addr != p_daddr || dmem_we != p_dwe || dmem_wdata != p_dwdata)) begin
                mon_viol = mon_viol + 1;
                $display("FAIL dmem_stable: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                         dmem_req, dmem_addr, dmem_we, dmem_wdata, p_daddr, p_dwe, p_dwdata);
            end
            p_dreq   <= dmem_req;
            p_drdy   <= dmem_ready;
            p_dwe    <= dmem_we;
            p_daddr  <= dmem_addr;
            p_dwdata <= dmem_wdata;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    function automatic int dut_regs();
        return int'({dut.rf[3], dut.rf[2], dut.rf[1], dut.rf[0]});
    endfunction

    // ---------------- reference model (instruction level) ----------------
    int   m_pc;
    int   m_rf [4];
    logic [7:0] m_dm [256];

    function automatic int sx8(input int v);
        return (v & 'h80) != 0 ? (v & MASK) - 256 : (v & MASK);
    endfunction

    function automatic int model_regs();
        return (m_rf[3] << 24) | (m_rf[2] << 16) | (m_rf[1] << 8) | m_rf[0];
    endfunction

    task automatic model_step(output int lat, output bit ill);
        logic [15:0] ins;
        int op, rs, rt, rd, fn, simm, av, bv, npc, ea;
        ins  = imem[m_pc];
        op   = int'(ins[15:12]);
        rs   = int'(ins[11:10]);
        rt   = int'(ins[9:8]);
        rd   = int'(ins[7:6]);
        fn   = int'(ins[3:0]);
        simm = sx8(int'(ins[7:0]));
        av   = m_rf[rs];
        bv   = m_rf[rt];
        ea   = (av + simm) & MASK;
        npc  = (m_pc + 2) & MASK;
        ill  = 1'b0;
        case (op)
            0: begin
                lat = 4;
                case (fn)
                    0: m_rf[rd] = (av + bv) & MASK;
                    1: m_rf[rd] = (av - bv) & MASK;
                    2: m_rf[rd] = av & bv;
                    3: m_rf[rd] = av | bv;
                    4: m_rf[rd] = (sx8(av) < sx8(bv)) ? 1 : 0;
                    default: lat = 3;
                endcase
            end
            1: begin m_rf[rt] = ea; lat = 4; end
            2: begin m_rf[rt] = int'(m_dm[ea]); lat = 5 + int'(dw); end
            3: begin m_dm[ea] = 8'(bv); lat = 4 + int'(dw); end
            4: begin
                if (av == bv) npc = (npc + 2 * simm) & MASK;
                lat = 3;
            end
            5: begin npc = int'(ins[11:0]) & MASK; lat = 2; end
            default: begin ill = 1'b1; lat = 2; end
        endcase
        lat  = lat + int'(iw);
        m_pc = npc;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0]  op;
        logic [11:0] rest;
        int unsigned c;
        c    = $urandom_range(0, 9);
        rest = 12'($urandom);
        case (c)
            0, 1, 2: begin op = 4'h0; rest[3:0] = 4'($urandom_range(0, 6)); end
            3, 4:    op = 4'h1;
            5:       op = 4'h2;
            6:       op = 4'h3;
            7:       op = 4'h4;
            default: op = ($urandom_range(0, 3) == 0) ? 4'h5 : 4'($urandom_range(6, 14));
        endcase
        return {op, rest};
    endfunction

    task automatic run_random(input int n);
        int cyc, last, got, lat;
        bit ill, pend;
        for (int i = 0; i < 256; i++) begin
            imem[i] = rand_instr();
            dmem[i] = 8'($urandom);
            m_dm[i] = dmem[i];
        end
        for (int r = 0; r < 4; r++) m_rf[r] = 0;
        m_pc = 0;
        iw = $urandom_range(0, 2);
        dw = $urandom_range(0, 3);
        do_reset();
        cyc = 0; last = 0; got = 0; pend = 1'b0;
        while ((got < n || pend) && cyc < n * 20) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                check("rand_pc", int'(pc), m_pc);
                check("rand_regs", dut_regs(), model_regs());
                pend = 1'b0;
            end
            if (retire && got < n) begin
                model_step(lat, ill);
                check("rand_latency", cyc - last, lat);
                check("rand_illegal", int'(illegal), int'(ill));
                last = cyc;
                got++;
                pend = 1'b1;
            end else if (illegal) begin
                check("rand_illegal_without_retire", int'(illegal), 0);
            end
        end
        check("rand_retired", got, n);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [15:0] w0, w1, w2, w20;
        int nret, dwait, exp_pc, ridx, exp_reg, exp_cyc;
    } vec_t;

    vec_t vecs [10];

    task automatic run_vec(input int k);
        vec_t v;
        int cyc, got, last;
        v = vecs[k];
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 8'h00;
        end
        imem[0] = v.w0; imem[2] = v.w1; imem[4] = v.w2; imem[8'h20] = v.w20;
        iw = 0;
        dw = v.dwait;
        do_reset();
        cyc = 0; got = 0; last = 0;
        while (got < v.nret && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (retire) begin
                got++;
                last = cyc;
            end
        end
        check($sformatf("vec%0d_retired", k), got, v.nret);
        @(negedge clk);
        check($sformatf("vec%0d_pc", k), int'(pc), v.exp_pc);
        check($sformatf("vec%0d_r%0d", k, v.ridx), int'(dut.rf[v.ridx]), v.exp_reg);
        check($sformatf("vec%0d_cycles", k), last, v.exp_cyc);
    endtask

    int cnt, bad;

    initial begin
        //              w0        w1        w2        w20       nret dw pc     ridx reg   cyc
        vecs[0] = '{16'h1105, 16'h12FD, 16'h06C0, 16'hF000, 3, 0, 'h06, 3, 2,    12};
        vecs[1] = '{16'h1105, 16'h3110, 16'h2210, 16'hF000, 3, 3, 'h06, 2, 5,    19};
        vecs[2] = '{16'h1105, 16'h5020, 16'hF000, 16'h4502, 3, 0, 'h26, 1, 5,    9};
        vecs[3] = '{16'h1105, 16'h5020, 16'hF000, 16'h4602, 3, 0, 'h22, 1, 5,    9};
        vecs[4] = '{16'h50AB, 16'hF000, 16'hF000, 16'hF000, 1, 0, 'hAB, 0, 0,    2};
        vecs[5] = '{16'h1105, 16'h12FD, 16'h09C4, 16'hF000, 3, 0, 'h06, 3, 1,    12};
        vecs[6] = '{16'h11FF, 16'h0540, 16'hF000, 16'hF000, 2, 0, 'h04, 1, 'hFE, 8};
        vecs[7] = '{16'h1105, 16'h7123, 16'hF000, 16'hF000, 2, 0, 'h04, 1, 5,    6};
        vecs[8] = '{16'h40FE, 16'hF000, 16'hF000, 16'hF000, 1, 0, 'hFE, 0, 0,    3};
        vecs[9] = '{16'h1105, 16'h05C5, 16'hF000, 16'hF000, 2, 0, 'h04, 3, 0,    7};

        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 8'h00;
        end

        // Outputs while reset is held.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_pc", int'(pc), 0);
        check("reset_imem_req", int'(imem_req), 0);
        check("reset_dmem_req", int'(dmem_req), 0);
        check("reset_flags", int'({retire, illegal, halted}), 0);

        for (int k = 0; k < 10; k++) run_vec(k);

        // HALT holds with no requests, then reset clears it.
        imem[0] = 16'hF000;
        iw = 1; dw = 0;
        do_reset();
        cnt = 0;
        while (!retire && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check("halt_retired", int'(retire), 1);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!halted || imem_req || dmem_req || pc != 8'h02) bad++;
        end
        check("halt_hold_bad_cycles", bad, 0);
        check("halt_halted", int'(halted), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("halt_reset_halted", int'(halted), 0);
        check("halt_reset_pc", int'(pc), 0);

        // Reset during a data-memory wait abandons the access.
        imem[0] = 16'h2210;
        iw = 0; dw = 5;
        do_reset();
        cnt = 0;
        while (!dmem_req && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        @(negedge clk);
        check("memwait_req_held", int'(dmem_req), 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("memwait_reset_dmem_req", int'(dmem_req), 0);
        check("memwait_reset_pc", int'(pc), 0);
        check("memwait_reset_fetch", int'({imem_req, imem_addr}), 'h100);

        for (int r = 0; r < 3; r++) run_random(150);

        check("protocol_monitor", mon_viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
